// File: rtl/stopwatch_timer_pkg.sv
// stopwatch_timer_pkg
//   Shared definitions for the stopwatch: controller state encoding,
//   per-field saturation values in packed BCD, and the two-digit BCD
//   increment helper used by the field counters.
package stopwatch_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_FULL    = 2'd3
  } state_t;

  localparam logic [7:0] MAX_HOUR_BCD  = 8'h99;
  localparam logic [7:0] MAX_MIN_BCD   = 8'h59;
  localparam logic [7:0] MAX_SEC_BCD   = 8'h59;
  localparam logic [7:0] MAX_CENTI_BCD = 8'h99;

  // Next value of a packed two-digit BCD number, ignoring the field's
  // own modulus (the caller wraps at its maximum before this is used).
  function automatic logic [7:0] bcd2_incr(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/stopwatch_timer_bcd2_counter.sv
// bcd2_counter
//   Two-digit packed BCD counter with a configurable maximum value.
//   Wraps to 00 when incremented at MAX_BCD and signals carry in that
//   same cycle so the next field can advance on the same edge.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset, value -> 00
//   clr   - synchronous clear, value -> 00 (overrides inc)
//   inc   - advance by one on the next edge
//   value - current count, tens [7:4], units [3:0]
//   carry - combinational: inc while value == MAX_BCD
module bcd2_counter
  import stopwatch_timer_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h99
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic       carry
);

  logic at_max;

  assign at_max = (value == MAX_BCD);
  assign carry  = inc && at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      if (at_max) begin
        value <= '0;
      end else begin
        value <= bcd2_incr(value);
      end
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// stopwatch_timer
//   Centisecond stopwatch with lap capture. A prescaler divides clk into
//   a centisecond tick while RUNNING; four chained BCD field counters hold
//   HH:MM:SS.CC and saturate at 99:59:59.99 by entering FULL.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   start, stop, clear, lap  - one-cycle command pulses
//                              (priority clear > start > stop; lap is
//                              independent but suppressed by clear)
//   hour/minute/second/centi_bcd      - live elapsed time, packed BCD
//   lap_hour/minute/second/centi_bcd  - last captured lap time
//   lap_valid                - pulses the cycle the lap registers show
//                              a new capture
//   running                  - high in RUNNING
//   full                     - high in FULL
module stopwatch_timer
  import stopwatch_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TICK_DIV = CLK_HZ / 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] hour_bcd,
  output logic [7:0] minute_bcd,
  output logic [7:0] second_bcd,
  output logic [7:0] centi_bcd,
  output logic [7:0] lap_hour_bcd,
  output logic [7:0] lap_minute_bcd,
  output logic [7:0] lap_second_bcd,
  output logic [7:0] lap_centi_bcd,
  output logic       lap_valid,
  output logic       running,
  output logic       full
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic          at_max;
  logic          count_inc;
  logic          saturate;
  logic          centi_carry;
  logic          second_carry;
  logic          minute_carry;
  logic          hour_carry;

  // ---------------------------------------------------------------------
  // Prescaler: counts only in RUNNING, holds elsewhere so a pause keeps
  // the sub-centisecond phase. Restarting from IDLE begins a fresh phase.
  // ---------------------------------------------------------------------
  assign tick = (state == ST_RUNNING) && (presc == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if ((state == ST_IDLE) && start) begin
      presc <= '0;
    end else if (state == ST_RUNNING) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Time-of-count: the tick is withheld at 99:59:59.99 so the chain never
  // wraps; that same tick drives the move to FULL instead.
  // ---------------------------------------------------------------------
  assign at_max = (hour_bcd   == MAX_HOUR_BCD) &&
                  (minute_bcd == MAX_MIN_BCD)  &&
                  (second_bcd == MAX_SEC_BCD)  &&
                  (centi_bcd  == MAX_CENTI_BCD);

  assign count_inc = tick && !at_max;

  // hour_carry cannot assert while the chain is gated at maximum; it is
  // folded in so any ripple out of the hour field still lands in FULL.
  assign saturate = (tick && at_max) || hour_carry;

  bcd2_counter #(.MAX_BCD(MAX_CENTI_BCD)) u_centi (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (count_inc),
    .value (centi_bcd),
    .carry (centi_carry)
  );

  bcd2_counter #(.MAX_BCD(MAX_SEC_BCD)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (centi_carry),
    .value (second_bcd),
    .carry (second_carry)
  );

  bcd2_counter #(.MAX_BCD(MAX_MIN_BCD)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (second_carry),
    .value (minute_bcd),
    .carry (minute_carry)
  );

  bcd2_counter #(.MAX_BCD(MAX_HOUR_BCD)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (minute_carry),
    .value (hour_bcd),
    .carry (hour_carry)
  );

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) state_next = ST_RUNNING;
        end
        ST_PAUSED: begin
          if (start) state_next = ST_RUNNING;
        end
        ST_RUNNING: begin
          // Saturation outranks a coincident stop so the block never
          // parks at maximum in PAUSED.
          if (saturate) begin
            state_next = ST_FULL;
          end else if (stop) begin
            state_next = ST_PAUSED;
          end
        end
        ST_FULL: begin
          state_next = ST_FULL;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign running = (state == ST_RUNNING);
  assign full    = (state == ST_FULL);

  // ---------------------------------------------------------------------
  // Lap capture: samples the live registers as they stand this cycle,
  // i.e. before any increment landing on the same edge.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_hour_bcd   <= '0;
      lap_minute_bcd <= '0;
      lap_second_bcd <= '0;
      lap_centi_bcd  <= '0;
      lap_valid      <= 1'b0;
    end else if (clear) begin
      lap_hour_bcd   <= '0;
      lap_minute_bcd <= '0;
      lap_second_bcd <= '0;
      lap_centi_bcd  <= '0;
      lap_valid      <= 1'b0;
    end else begin
      lap_valid <= lap;
      if (lap) begin
        lap_hour_bcd   <= hour_bcd;
        lap_minute_bcd <= minute_bcd;
        lap_second_bcd <= second_bcd;
        lap_centi_bcd  <= centi_bcd;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer
//   Self-checking bench for stopwatch_timer with TICK_DIV = 4. The
//   reference model keeps elapsed time as a plain centisecond integer and
//   converts to BCD with arithmetic for comparison every cycle.
module tb_stopwatch_timer;

  localparam int unsigned TD   = 4;
  localparam int unsigned MAXT = 35999999;  // 99:59:59.99 in centiseconds

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_FULL} m_state_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       clear;
  logic       lap;
  logic [7:0] hour_bcd;
  logic [7:0] minute_bcd;
  logic [7:0] second_bcd;
  logic [7:0] centi_bcd;
  logic [7:0] lap_hour_bcd;
  logic [7:0] lap_minute_bcd;
  logic [7:0] lap_second_bcd;
  logic [7:0] lap_centi_bcd;
  logic       lap_valid;
  logic       running;
  logic       full;

  logic [31:0] live_bcd;
  logic [31:0] lap_bcd;
  logic [7:0]  pre_h, pre_m, pre_s, pre_c;

  int n_checks = 0;
  int n_fail   = 0;

  m_state_t    m_st;
  int unsigned m_t;
  int unsigned m_lap;
  int unsigned m_presc;
  bit          m_lv;

  assign live_bcd = {hour_bcd, minute_bcd, second_bcd, centi_bcd};
  assign lap_bcd  = {lap_hour_bcd, lap_minute_bcd, lap_second_bcd, lap_centi_bcd};

  stopwatch_timer #(.TICK_DIV(TD)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .clear          (clear),
    .lap            (lap),
    .hour_bcd       (hour_bcd),
    .minute_bcd     (minute_bcd),
    .second_bcd     (second_bcd),
    .centi_bcd      (centi_bcd),
    .lap_hour_bcd   (lap_hour_bcd),
    .lap_minute_bcd (lap_minute_bcd),
    .lap_second_bcd (lap_second_bcd),
    .lap_centi_bcd  (lap_centi_bcd),
    .lap_valid      (lap_valid),
    .running        (running),
    .full           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] d2(input int unsigned x);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = 4'(x / 10);
    units = 4'(x % 10);
    return {tens, units};
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned t);
    return {d2(t / 360000), d2((t / 6000) % 60), d2((t / 100) % 60), d2(t % 100)};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_t = 0; m_lap = 0; m_presc = 0; m_lv = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c, input bit l);
    m_state_t nst;
    bit       tk;
    if (c) begin
      m_t = 0; m_lap = 0; m_presc = 0; m_st = M_IDLE; m_lv = 1'b0;
    end else begin
      m_lv = l;
      if (l) m_lap = m_t;
      tk = (m_st == M_RUN) && (m_presc == TD - 1);
      if (m_st == M_RUN) m_presc = tk ? 0 : m_presc + 1;
      nst = m_st;
      if (s && (m_st == M_IDLE || m_st == M_PAUSE)) begin
        nst = M_RUN;
        if (m_st == M_IDLE) m_presc = 0;
      end else if (p && m_st == M_RUN) begin
        nst = M_PAUSE;
      end
      if (tk) begin
        if (m_t == MAXT) nst = M_FULL;
        else m_t = m_t + 1;
      end
      m_st = nst;
    end
  endtask

  task automatic compare_all();
    check("live", live_bcd, to_bcd(m_t));
    check("lap", lap_bcd, to_bcd(m_lap));
    check("flags", 32'({running, full, lap_valid}),
          32'({m_st == M_RUN, m_st == M_FULL, m_lv}));
  endtask

  task automatic step(input bit s, input bit p, input bit c, input bit l);
    start = s; stop = p; clear = c; lap = l;
    @(posedge clk);
    model_edge(s, p, c, l);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    compare_all();
  endtask

  // Loads the live counters directly while the stopwatch is not counting.
  task automatic preload(input int unsigned t);
    logic [31:0] b;
    b = to_bcd(t);
    pre_h = b[31:24]; pre_m = b[23:16]; pre_s = b[15:8]; pre_c = b[7:0];
    force dut.u_hour.value  = pre_h;
    force dut.u_min.value   = pre_m;
    force dut.u_sec.value   = pre_s;
    force dut.u_centi.value = pre_c;
    #1;
    release dut.u_hour.value;
    release dut.u_min.value;
    release dut.u_sec.value;
    release dut.u_centi.value;
    m_t = t;
  endtask

  task automatic run_to_time(input int unsigned target, input int budget, input string tag);
    int n;
    n = 0;
    while (m_t != target && n < budget) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check(tag, live_bcd, to_bcd(target));
  endtask

  initial begin
    int n;
    bit s, p, c, l;

    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_live", live_bcd, 32'h0);
    check("rst_lap", lap_bcd, 32'h0);
    check("rst_flags", 32'({running, full, lap_valid}), 32'h0);
    rst = 1'b0;

    // One second of counting.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (400) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t_1s", live_bcd, 32'h0000_0100);
    check("t_1s_running", 32'(running), 32'd1);

    // Second -> minute rollover, then minute -> hour via preload.
    run_to_time(5999, 24000, "t_59_99");
    run_to_time(6000, 8, "t_1min");
    check("t_1min_const", live_bcd, 32'h0001_0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    preload(359999);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_time(360000, 8, "t_1h");
    check("t_1h_const", live_bcd, 32'h0100_0000);

    // Pause holds value and prescaler phase.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (200) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t_050", live_bcd, 32'h0000_0050);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("pause_hold", live_bcd, 32'h0000_0050);
    check("pause_flags", 32'({running, full}), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_pre", live_bcd, 32'h0000_0050);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("resume_phase", live_bcd, 32'h0000_0051);

    // Lap coincident with a tick, then clear+lap together.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(m_t == 25 && m_presc == TD - 1) && n < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_025", lap_bcd, 32'h0000_0025);
    check("lap_live_026", live_bcd, 32'h0000_0026);
    check("lap_valid_hi", 32'(lap_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_valid_lo", 32'(lap_valid), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("clrlap_regs", lap_bcd, 32'h0);
    check("clrlap_valid", 32'(lap_valid), 32'd0);

    // Saturation at 99:59:59.99.
    preload(MAXT - 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (m_st != M_FULL && n < 16) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("full_live", live_bcd, 32'h9959_5999);
    check("full_flags", 32'({running, full}), 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_start_ign", 32'({running, full}), 32'h1);
    check("full_hold", live_bcd, 32'h9959_5999);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("full_clear", live_bcd, 32'h0);
    check("full_clear_flags", 32'({running, full}), 32'h0);

    // Random commands from zero.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(99) < 5);
      p = ($urandom_range(99) < 3);
      c = ($urandom_range(99) < 1);
      l = ($urandom_range(99) < 5);
      step(s, p, c, l);
    end

    // Random commands close to saturation.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    preload(MAXT - 300);
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(99) < 20);
      p = ($urandom_range(99) < 3);
      l = ($urandom_range(99) < 5);
      step(s, p, 1'b0, l);
    end

    // Asynchronous reset between edges while running.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (48) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_live", live_bcd, 32'h0);
    check("arst_lap", lap_bcd, 32'h0);
    check("arst_flags", 32'({running, full, lap_valid}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_idle", 32'({running, full}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
